regwb: RTL and testbench
========================

REGWB -- requirements
Module: regwb

Interface
REQ-001 Parameter RADDRWIDTH, default 3, register address width; r0 reads as zero and is never written.
REQ-002 Parameter REGWIDTH, default 16, data width.
REQ-003 Parameter LQDEPTH, default 2, maximum outstanding loads (>=1).
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-006 alu_valid  in  1  ALU result present this cycle; always accepted.
REQ-007 alu_waddr  in  RADDRWIDTH  ALU destination register.
REQ-008 alu_wdata  in  REGWIDTH  ALU result.
REQ-009 ld_issue  in  1  load issued; its destination is tracked.
REQ-010 ld_waddr  in  RADDRWIDTH  load destination register.
REQ-011 ld_issue_ready  out  1  combinational; 1 when outstanding < LQDEPTH.
REQ-012 ld_resp_valid  in  1  load data returned; responses arrive in issue order.
REQ-013 ld_resp_data  in  REGWIDTH  load data.
REQ-014 ld_resp_ready  out  1  combinational; response accepted when ld_resp_valid && ld_resp_ready.
REQ-015 we / waddr / wdata  out  1 / RADDRWIDTH / REGWIDTH  registered register-file write port.
REQ-016 chk_addr_a/b/c  in  RADDRWIDTH  each; scoreboard query addresses.
REQ-017 busy_a/b/c  out  1  each; combinational; register not yet valid in the file.
REQ-018 err  out  1  sticky protocol-violation flag.

Function
REQ-019 Tag FIFO: LQDEPTH entries of RADDRWIDTH; push ld_waddr on accepted ld_issue (ld_issue && ld_issue_ready); pop head on accepted response.
REQ-020 Load result holder (lr_valid, lr_addr, lr_data): loaded on accepted response with popped head address and ld_resp_data.
REQ-021 outstanding = FIFO count + lr_valid; decrements on the edge lr is written back.
REQ-022 alu_wr = alu_valid && alu_waddr != 0.
REQ-023 Write-port priority per edge: alu_wr -> we=1, waddr=alu_waddr, wdata=alu_wdata; else lr_valid -> we=(lr_addr!=0), waddr=lr_addr, wdata=lr_data, lr_valid cleared; else we=0, waddr/wdata hold.
REQ-024 ld_resp_ready = !lr_valid || !alu_wr, and tag FIFO non-empty.
REQ-025 Simultaneous drain and refill of lr on the same edge: new response is captured; old one is written.
REQ-026 Latency: ALU result -> we high 1 cycle later; load response -> we high 2 cycles later when ALU idle, delayed one cycle per intervening alu_wr.
REQ-027 Pending counter per register 1..2**RADDRWIDTH-1, width clog2(LQDEPTH+1): +1 on accepted issue to that register, -1 on lr writeback; both same edge -> unchanged. r0 is never counted.
REQ-028 busy_x = (chk_addr_x != 0) && (pending[chk_addr_x] != 0 || (we && waddr == chk_addr_x)).
REQ-029 err set on: alu_wr to a register with pending != 0; ld_issue while !ld_issue_ready (issue ignored); ld_resp_valid with empty tag FIFO (response ignored). err is cleared only by reset.
REQ-030 FIFO pointers wrap modulo LQDEPTH; full blocks issue; empty blocks response acceptance.

Reset
REQ-031 While rst=0 at posedge: we=0, waddr=0, wdata=0, FIFO empty, lr_valid=0, all pending=0, err=0; ld_issue_ready=1, ld_resp_ready=0.
REQ-032 Reset mid-operation discards all outstanding loads and any buffered result; inputs are ignored during reset.

Verification
REQ-033 alu_valid=1, alu_waddr=3, alu_wdata=0x1234 -> next cycle we=1, waddr=3, wdata=0x1234, busy for addr 3 high that cycle only.
REQ-034 ld_issue r5; response 0xBEEF two cycles later with ALU idle -> busy_a(5)=1 from issue through the we cycle; we=1, waddr=5, wdata=0xBEEF two cycles after response.
REQ-035 Load response for r2 coincident with alu_wr r4 on three consecutive cycles -> writes r4 x3 first, then r2; ld_resp_ready=0 while lr is full and ALU busy.
REQ-036 Two loads to r6 (LQDEPTH=2) -> ld_issue_ready=0; busy(6) stays 1 until second writeback; third issue -> err=1 and issue dropped.
REQ-037 ld_resp_valid with nothing outstanding -> err=1, no write; load to r0 -> response consumed, we=0, busy(0)=0.
REQ-038 rst=0 with 2 loads outstanding -> all outputs at reset values next cycle; late response after reset -> not accepted, err=1.

Source files
------------

// File: rtl/regwb_if.sv
`default_nettype none
// ============================================================================
// Module      : regwb_if
// Description : Bundle of the ALU result, load issue/response, register-file
//               write port and scoreboard query signals of regwb.
//   master : drives alu_*, ld_issue/ld_waddr, ld_resp_*, chk_addr_*;
//            observes ld_issue_ready, ld_resp_ready, we/waddr/wdata,
//            busy_*, err.
//   slave  : the regwb side (directions mirrored).
// Revision    : 1.0 - initial release
// ============================================================================
interface regwb_if #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16
);
  logic                  alu_valid;
  logic [RADDRWIDTH-1:0] alu_waddr;
  logic [REGWIDTH-1:0]   alu_wdata;
  logic                  ld_issue;
  logic [RADDRWIDTH-1:0] ld_waddr;
  logic                  ld_issue_ready;
  logic                  ld_resp_valid;
  logic [REGWIDTH-1:0]   ld_resp_data;
  logic                  ld_resp_ready;
  logic                  we;
  logic [RADDRWIDTH-1:0] waddr;
  logic [REGWIDTH-1:0]   wdata;
  logic [RADDRWIDTH-1:0] chk_addr_a;
  logic [RADDRWIDTH-1:0] chk_addr_b;
  logic [RADDRWIDTH-1:0] chk_addr_c;
  logic                  busy_a;
  logic                  busy_b;
  logic                  busy_c;
  logic                  err;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output ld_issue, ld_waddr,
    input  ld_issue_ready,
    output ld_resp_valid, ld_resp_data,
    input  ld_resp_ready,
    input  we, waddr, wdata,
    output chk_addr_a, chk_addr_b, chk_addr_c,
    input  busy_a, busy_b, busy_c,
    input  err
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  ld_issue, ld_waddr,
    output ld_issue_ready,
    input  ld_resp_valid, ld_resp_data,
    output ld_resp_ready,
    output we, waddr, wdata,
    input  chk_addr_a, chk_addr_b, chk_addr_c,
    output busy_a, busy_b, busy_c,
    output err
  );
endinterface
`default_nettype wire

// File: rtl/regwb.sv
`default_nettype none
// ============================================================================
// Module      : regwb
// Description : Register-file writeback arbiter. Merges single-cycle ALU
//               results with in-order load responses onto one registered
//               write port, tracks outstanding load destinations in a tag
//               FIFO, and keeps a per-register pending count for hazard
//               queries.
// Ports       : clk  - clock
//               rst  - synchronous reset, active low
//               bus  - regwb_if.slave (ALU in, load issue/response,
//                      write port, busy queries, sticky err)
// Revision    : 1.0 - initial release
// ============================================================================
module regwb #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16,
  parameter int LQDEPTH    = 2
) (
  input wire logic clk,
  input wire logic rst,
  regwb_if.slave   bus
);

  localparam int C_NREG = 1 << RADDRWIDTH;
  localparam int C_CNTW = $clog2(LQDEPTH + 1);
  localparam int C_PTRW = (LQDEPTH > 1) ? $clog2(LQDEPTH) : 1;
  localparam int C_OUTW = C_CNTW + 1;

  // Tag FIFO
  logic [RADDRWIDTH-1:0] tag_q [LQDEPTH];
  logic [RADDRWIDTH-1:0] tag_d [LQDEPTH];
  logic [C_PTRW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [C_PTRW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [C_CNTW-1:0]     cnt_q, cnt_d;

  // Load result holder
  logic                  lr_valid_q, lr_valid_d;
  logic [RADDRWIDTH-1:0] lr_addr_q, lr_addr_d;
  logic [REGWIDTH-1:0]   lr_data_q, lr_data_d;

  // Write port and error flag
  logic                  we_q, we_d;
  logic [RADDRWIDTH-1:0] waddr_q, waddr_d;
  logic [REGWIDTH-1:0]   wdata_q, wdata_d;
  logic                  err_q, err_d;

  // Pending loads per register; entry 0 is kept at zero
  logic [C_CNTW-1:0]     pend_q [C_NREG];
  logic [C_CNTW-1:0]     pend_d [C_NREG];

  logic                  w_alu_wr;
  logic                  w_fifo_empty;
  logic [C_OUTW-1:0]     w_outstanding;
  logic                  w_issue_ready;
  logic                  w_resp_ready;
  logic                  w_issue_acc;
  logic                  w_resp_acc;
  logic                  w_lr_drain;
  logic [RADDRWIDTH-1:0] w_head;

  assign w_alu_wr      = bus.alu_valid && (bus.alu_waddr != '0);
  assign w_fifo_empty  = (cnt_q == '0);
  // The buffered result still occupies a load slot until it is written
  assign w_outstanding = C_OUTW'(cnt_q) + C_OUTW'(lr_valid_q);
  assign w_issue_ready = (w_outstanding < C_OUTW'(LQDEPTH));
  // lr can take a new response if it is empty or is draining this edge
  assign w_resp_ready  = (!lr_valid_q || !w_alu_wr) && !w_fifo_empty;
  assign w_issue_acc   = bus.ld_issue && w_issue_ready;
  assign w_resp_acc    = bus.ld_resp_valid && w_resp_ready;
  assign w_lr_drain    = lr_valid_q && !w_alu_wr;
  assign w_head        = tag_q[rd_ptr_q];

  assign bus.ld_issue_ready = w_issue_ready;
  assign bus.ld_resp_ready  = w_resp_ready;
  assign bus.we             = we_q;
  assign bus.waddr          = waddr_q;
  assign bus.wdata          = wdata_q;
  assign bus.err            = err_q;

  assign bus.busy_a = (bus.chk_addr_a != '0) &&
                      ((pend_q[bus.chk_addr_a] != '0) || (we_q && (waddr_q == bus.chk_addr_a)));
  assign bus.busy_b = (bus.chk_addr_b != '0) &&
                      ((pend_q[bus.chk_addr_b] != '0) || (we_q && (waddr_q == bus.chk_addr_b)));
  assign bus.busy_c = (bus.chk_addr_c != '0) &&
                      ((pend_q[bus.chk_addr_c] != '0) || (we_q && (waddr_q == bus.chk_addr_c)));

  // Tag FIFO next state
  always_comb begin
    for (int i = 0; i < LQDEPTH; i++) begin
      tag_d[i] = tag_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_issue_acc) begin
      tag_d[wr_ptr_q] = bus.ld_waddr;
      wr_ptr_d = (wr_ptr_q == C_PTRW'(LQDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_resp_acc) begin
      rd_ptr_d = (rd_ptr_q == C_PTRW'(LQDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({w_issue_acc, w_resp_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Load result holder and write-port arbitration (ALU has priority)
  always_comb begin
    lr_valid_d = lr_valid_q;
    lr_addr_d  = lr_addr_q;
    lr_data_d  = lr_data_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (w_alu_wr) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_waddr;
      wdata_d = bus.alu_wdata;
    end else if (lr_valid_q) begin
      // Loads to r0 still retire through the port, just without a write
      we_d       = (lr_addr_q != '0);
      waddr_d    = lr_addr_q;
      wdata_d    = lr_data_q;
      lr_valid_d = 1'b0;
    end
    // A response accepted on the drain edge refills lr immediately
    if (w_resp_acc) begin
      lr_valid_d = 1'b1;
      lr_addr_d  = w_head;
      lr_data_d  = bus.ld_resp_data;
    end
  end

  // Pending counters and sticky error
  always_comb begin
    for (int i = 0; i < C_NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (i == 0) begin
        pend_d[i] = '0;
      end else if ((w_issue_acc && (bus.ld_waddr == RADDRWIDTH'(i))) &&
                   !(w_lr_drain && (lr_addr_q == RADDRWIDTH'(i)))) begin
        pend_d[i] = pend_q[i] + 1'b1;
      end else if (!(w_issue_acc && (bus.ld_waddr == RADDRWIDTH'(i))) &&
                   (w_lr_drain && (lr_addr_q == RADDRWIDTH'(i)))) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
    err_d = err_q
          | (w_alu_wr && (pend_q[bus.alu_waddr] != '0))
          | (bus.ld_issue && !w_issue_ready)
          | (bus.ld_resp_valid && w_fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LQDEPTH; i++) begin
        tag_q[i] <= '0;
      end
      for (int i = 0; i < C_NREG; i++) begin
        pend_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lr_valid_q <= 1'b0;
      lr_addr_q  <= '0;
      lr_data_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < LQDEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
      for (int i = 0; i < C_NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lr_valid_q <= lr_valid_d;
      lr_addr_q  <= lr_addr_d;
      lr_data_q  <= lr_data_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regwb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwb
// Description : Directed testbench for regwb with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regwb_if #(.RADDRWIDTH(3), .REGWIDTH(16)) bus ();

  regwb #(.RADDRWIDTH(3), .REGWIDTH(16), .LQDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_valid     = 1'b0;
    bus.alu_waddr     = '0;
    bus.alu_wdata     = '0;
    bus.ld_issue      = 1'b0;
    bus.ld_waddr      = '0;
    bus.ld_resp_valid = 1'b0;
    bus.ld_resp_data  = '0;
    bus.chk_addr_a    = '0;
    bus.chk_addr_b    = '0;
    bus.chk_addr_c    = '0;
  endtask

  // Advance past the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd2; bus.alu_wdata = 16'h5a5a;
    bus.chk_addr_c = 3'd2;
    cyc();
    cyc();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", bus.we); end
    checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", bus.waddr); end
    checks++; if (bus.wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", bus.wdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", bus.err); end
    checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0h expected 1", bus.ld_issue_ready); end
    checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %0h expected 0", bus.ld_resp_ready); end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_alu();
    idle();
    bus.chk_addr_a = 3'd3;
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd3; bus.alu_wdata = 16'h1234;
    #1;
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL alu_busy_before: got %0h expected 0", bus.busy_a); end
    cyc();
    idle(); bus.chk_addr_a = 3'd3;
    #1;
    checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL alu_we: got %0h expected 1", bus.we); end
    checks++; if (bus.waddr !== 3'd3) begin errors++; $display("FAIL alu_waddr: got %0h expected 3", bus.waddr); end
    checks++; if (bus.wdata !== 16'h1234) begin errors++; $display("FAIL alu_wdata: got %0h expected 1234", bus.wdata); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL alu_busy_wcycle: got %0h expected 1", bus.busy_a); end
    cyc();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL alu_we_after: got %0h expected 0", bus.we); end
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL alu_busy_after: got %0h expected 0", bus.busy_a); end
    checks++; if (bus.wdata !== 16'h1234) begin errors++; $display("FAIL alu_wdata_hold: got %0h expected 1234", bus.wdata); end
    // ALU result to r0 is discarded
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd0; bus.alu_wdata = 16'hffff;
    cyc();
    idle();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL alu_r0_we: got %0h expected 0", bus.we); end
    checks++; if (bus.wdata !== 16'h1234) begin errors++; $display("FAIL alu_r0_wdata: got %0h expected 1234", bus.wdata); end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd1; bus.alu_wdata = 16'h0011;
    cyc();
    bus.alu_waddr = 3'd2; bus.alu_wdata = 16'h0022;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd1, 16'h0011}) begin errors++; $display("FAIL b2b_1: got %0h/%0h/%0h expected 1/1/0011", bus.we, bus.waddr, bus.wdata); end
    cyc();
    bus.alu_waddr = 3'd3; bus.alu_wdata = 16'h0033;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd2, 16'h0022}) begin errors++; $display("FAIL b2b_2: got %0h/%0h/%0h expected 1/2/0022", bus.we, bus.waddr, bus.wdata); end
    cyc();
    idle();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd3, 16'h0033}) begin errors++; $display("FAIL b2b_3: got %0h/%0h/%0h expected 1/3/0033", bus.we, bus.waddr, bus.wdata); end
    cyc();
  endtask

  task automatic test_load();
    idle();
    bus.chk_addr_a = 3'd5;
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd5;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL ld_issue_ready: got %0h expected 1", bus.ld_issue_ready); end
    checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL ld_resp_ready_empty: got %0h expected 0", bus.ld_resp_ready); end
    cyc();
    idle(); bus.chk_addr_a = 3'd5;
    #1;
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL ld_busy_c1: got %0h expected 1", bus.busy_a); end
    checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL ld_resp_ready: got %0h expected 1", bus.ld_resp_ready); end
    cyc();
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'hbeef;
    #1;
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL ld_busy_c2: got %0h expected 1", bus.busy_a); end
    cyc();
    idle(); bus.chk_addr_a = 3'd5;
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL ld_we_early: got %0h expected 0", bus.we); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL ld_busy_c3: got %0h expected 1", bus.busy_a); end
    cyc();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd5, 16'hbeef}) begin errors++; $display("FAIL ld_write: got %0h/%0h/%0h expected 1/5/beef", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL ld_busy_wcycle: got %0h expected 1", bus.busy_a); end
    cyc();
    #1;
    checks++; if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL ld_busy_done: got %0h expected 0", bus.busy_a); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ld_err: got %0h expected 0", bus.err); end
  endtask

  task automatic test_contention();
    idle();
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd2;
    cyc();
    bus.ld_waddr = 3'd7;
    cyc();
    idle(); bus.chk_addr_a = 3'd2; bus.chk_addr_b = 3'd7;
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd4; bus.alu_wdata = 16'h0041;
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'h2222;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL ct_issue_ready: got %0h expected 0", bus.ld_issue_ready); end
    checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL ct_resp_ready_c2: got %0h expected 1", bus.ld_resp_ready); end
    cyc();
    bus.alu_wdata = 16'h0042; bus.ld_resp_data = 16'h7777;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd4, 16'h0041}) begin errors++; $display("FAIL ct_w1: got %0h/%0h/%0h expected 1/4/0041", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL ct_resp_ready_c3: got %0h expected 0", bus.ld_resp_ready); end
    cyc();
    bus.alu_wdata = 16'h0043;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd4, 16'h0042}) begin errors++; $display("FAIL ct_w2: got %0h/%0h/%0h expected 1/4/0042", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL ct_resp_ready_c4: got %0h expected 0", bus.ld_resp_ready); end
    cyc();
    bus.alu_valid = 1'b0; bus.alu_waddr = 3'd0; bus.alu_wdata = 16'h0;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd4, 16'h0043}) begin errors++; $display("FAIL ct_w3: got %0h/%0h/%0h expected 1/4/0043", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL ct_resp_ready_c5: got %0h expected 1", bus.ld_resp_ready); end
    cyc();
    idle(); bus.chk_addr_a = 3'd2; bus.chk_addr_b = 3'd7;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd2, 16'h2222}) begin errors++; $display("FAIL ct_w_r2: got %0h/%0h/%0h expected 1/2/2222", bus.we, bus.waddr, bus.wdata); end
    checks++; if ({bus.busy_a, bus.busy_b} !== 2'b11) begin errors++; $display("FAIL ct_busy_c6: got %0b expected 11", {bus.busy_a, bus.busy_b}); end
    cyc();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd7, 16'h7777}) begin errors++; $display("FAIL ct_w_r7: got %0h/%0h/%0h expected 1/7/7777", bus.we, bus.waddr, bus.wdata); end
    checks++; if ({bus.busy_a, bus.busy_b} !== 2'b01) begin errors++; $display("FAIL ct_busy_c7: got %0b expected 01", {bus.busy_a, bus.busy_b}); end
    cyc();
    #1;
    checks++; if ({bus.we, bus.busy_b, bus.err} !== 3'b000) begin errors++; $display("FAIL ct_done: got %0b expected 000", {bus.we, bus.busy_b, bus.err}); end
  endtask

  task automatic test_full();
    idle();
    bus.chk_addr_a = 3'd6;
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd6;
    cyc();
    cyc();
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_issue_ready: got %0h expected 0", bus.ld_issue_ready); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL full_err_before: got %0h expected 0", bus.err); end
    cyc();
    idle(); bus.chk_addr_a = 3'd6;
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL full_err: got %0h expected 1", bus.err); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'h0601;
    cyc();
    bus.ld_resp_data = 16'h0602;
    #1;
    checks++; if (bus.ld_resp_ready !== 1'b1) begin errors++; $display("FAIL full_resp_ready: got %0h expected 1", bus.ld_resp_ready); end
    cyc();
    idle(); bus.chk_addr_a = 3'd6;
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd6, 16'h0601}) begin errors++; $display("FAIL full_w1: got %0h/%0h/%0h expected 1/6/0601", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL full_busy_w1: got %0h expected 1", bus.busy_a); end
    checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL full_issue_ready_c5: got %0h expected 1", bus.ld_issue_ready); end
    cyc();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 3'd6, 16'h0602}) begin errors++; $display("FAIL full_w2: got %0h/%0h/%0h expected 1/6/0602", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL full_busy_w2: got %0h expected 1", bus.busy_a); end
    cyc();
    #1;
    checks++; if ({bus.busy_a, bus.we, bus.ld_resp_ready} !== 3'b000) begin errors++; $display("FAIL full_done: got %0b expected 000", {bus.busy_a, bus.we, bus.ld_resp_ready}); end
  endtask

  task automatic test_spurious();
    apply_reset();
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'hdead;
    #1;
    checks++; if (bus.ld_resp_ready !== 1'b0) begin errors++; $display("FAIL sp_resp_ready: got %0h expected 0", bus.ld_resp_ready); end
    cyc();
    idle();
    #1;
    checks++; if ({bus.err, bus.we} !== 2'b10) begin errors++; $display("FAIL sp_err_we: got %0b expected 10", {bus.err, bus.we}); end
    cyc();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL sp_no_write: got %0h expected 0", bus.we); end
  endtask

  task automatic test_load_r0();
    apply_reset();
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd0;
    cyc();
    idle();
    #1;
    checks++; if ({bus.busy_a, bus.ld_resp_ready} !== 2'b01) begin errors++; $display("FAIL r0_busy_ready: got %0b expected 01", {bus.busy_a, bus.ld_resp_ready}); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'h5555;
    cyc();
    idle();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL r0_we_c1: got %0h expected 0", bus.we); end
    cyc();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 3'd0, 16'h5555}) begin errors++; $display("FAIL r0_drain: got %0h/%0h/%0h expected 0/0/5555", bus.we, bus.waddr, bus.wdata); end
    checks++; if ({bus.ld_resp_ready, bus.ld_issue_ready, bus.err, bus.busy_a} !== 4'b0100) begin errors++; $display("FAIL r0_state: got %0b expected 0100", {bus.ld_resp_ready, bus.ld_issue_ready, bus.err, bus.busy_a}); end
  endtask

  task automatic test_err_alu();
    apply_reset();
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd1;
    cyc();
    idle();
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd1; bus.alu_wdata = 16'h0101;
    #1;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ea_err_before: got %0h expected 0", bus.err); end
    cyc();
    idle();
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ea_err: got %0h expected 1", bus.err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd4; bus.alu_wdata = 16'h00aa;
    bus.ld_issue = 1'b1; bus.ld_waddr = 3'd3;
    cyc();
    bus.alu_valid = 1'b0;
    bus.ld_waddr = 3'd5;
    cyc();
    idle(); bus.chk_addr_a = 3'd3; bus.chk_addr_b = 3'd5;
    #1;
    checks++; if ({bus.busy_a, bus.busy_b, bus.ld_issue_ready} !== 3'b110) begin errors++; $display("FAIL rm_pre: got %0b expected 110", {bus.busy_a, bus.busy_b, bus.ld_issue_ready}); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 16'habcd;
    bus.alu_valid = 1'b1; bus.alu_waddr = 3'd6; bus.alu_wdata = 16'h6666;
    rst = 1'b0;
    cyc();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b0, 3'd0, 16'h0}) begin errors++; $display("FAIL rm_port: got %0h/%0h/%0h expected 0/0/0", bus.we, bus.waddr, bus.wdata); end
    checks++; if ({bus.err, bus.ld_issue_ready, bus.ld_resp_ready} !== 3'b010) begin errors++; $display("FAIL rm_flags: got %0b expected 010", {bus.err, bus.ld_issue_ready, bus.ld_resp_ready}); end
    checks++; if ({bus.busy_a, bus.busy_b} !== 2'b00) begin errors++; $display("FAIL rm_busy: got %0b expected 00", {bus.busy_a, bus.busy_b}); end
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_waddr = 3'd0; bus.alu_wdata = 16'h0;
    cyc();
    idle();
    #1;
    checks++; if ({bus.err, bus.we} !== 2'b10) begin errors++; $display("FAIL rm_late_resp: got %0b expected 10", {bus.err, bus.we}); end
    cyc();
    #1;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rm_no_write: got %0h expected 0", bus.we); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_contention();
    test_full();
    test_spurious();
    test_load_r0();
    test_err_alu();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
